// File: rtl/tmds_rx_decode.sv
// TMDS receiver back end: decodes three word-aligned channels into pixels and syncs,
// then measures active width/height and locks once the same timing repeats.
module tmds_rx_decode #(
  parameter int LOCK_FRAMES = 2,
  parameter int DIM_W       = 12
) (
  input  logic             i_pixclk,
  input  logic             reset,
  input  logic [9:0]       i_TMDS_red,
  input  logic [9:0]       i_TMDS_grn,
  input  logic [9:0]       i_TMDS_blu,
  output logic [7:0]       o_red,
  output logic [7:0]       o_grn,
  output logic [7:0]       o_blu,
  output logic             o_de,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_newline,
  output logic             o_newframe,
  output logic [DIM_W-1:0] o_width,
  output logic [DIM_W-1:0] o_height,
  output logic             o_locked,
  output logic             o_err
);

  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;

  localparam logic [DIM_W-1:0] DIM_MAX    = '1;
  localparam logic [DIM_W-1:0] DIM_ONE    = DIM_W'(1);
  localparam int               MATCH_W    = $clog2(LOCK_FRAMES + 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_FRAMES - 1);
  localparam logic [MATCH_W-1:0] MATCH_ONE  = MATCH_W'(1);

  function automatic logic is_token(input logic [9:0] s);
    return (s == TOK_00) || (s == TOK_01) || (s == TOK_10) || (s == TOK_11);
  endfunction

  function automatic logic [1:0] token_code(input logic [9:0] s);
    logic [1:0] c;
    case (s)
      TOK_01:  c = 2'b01;
      TOK_10:  c = 2'b10;
      TOK_11:  c = 2'b11;
      default: c = 2'b00;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] tmds_data(input logic [9:0] s);
    logic [7:0] q;
    logic [7:0] d;
    q    = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
    return d;
  endfunction

  // Stage 1: register the raw symbols; vld_q keeps a flushed pipeline from looking like data
  logic [9:0] sym_d [3];
  logic [9:0] sym_q [3];
  logic       vld_d, vld_q;

  always_comb begin
    sym_d[0] = i_TMDS_red;
    sym_d[1] = i_TMDS_grn;
    sym_d[2] = i_TMDS_blu;
    vld_d    = 1'b1;
  end

  always_ff @(posedge i_pixclk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) sym_q[i] <= '0;
      vld_q <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) sym_q[i] <= sym_d[i];
      vld_q <= vld_d;
    end
  end

  logic [7:0] dec [3];
  logic [2:0] ctl;

  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    assign dec[gi] = tmds_data(sym_q[gi]);
    assign ctl[gi] = is_token(sym_q[gi]);
  end

  // Stage 2: classify the symbol triple and produce the registered video outputs
  logic       all_data, all_ctl, vsync_rise;
  logic [1:0] blu_code;
  logic [7:0] red_d, grn_d, blu_d, red_q, grn_q, blu_q;
  logic       de_d, de_q, hsync_d, hsync_q, vsync_d, vsync_q, err_d, err_q;
  logic       newline_d, newline_q, newframe_d, newframe_q, pend_d, pend_q;

  always_comb begin
    all_data   = vld_q & ~(|ctl);
    all_ctl    = vld_q & (&ctl);
    blu_code   = token_code(sym_q[2]);
    de_d       = all_data;
    red_d      = all_data ? dec[0] : 8'd0;
    grn_d      = all_data ? dec[1] : 8'd0;
    blu_d      = all_data ? dec[2] : 8'd0;
    hsync_d    = all_ctl ? blu_code[0] : hsync_q;
    vsync_d    = all_ctl ? blu_code[1] : vsync_q;
    err_d      = vld_q & ~all_data & ~all_ctl;
    newline_d  = de_d & ~de_q;
    vsync_rise = vsync_d & ~vsync_q;
    newframe_d = newline_d & pend_q;
    pend_d     = pend_q;
    if (vsync_rise)     pend_d = 1'b1;
    else if (newline_d) pend_d = 1'b0;
  end

  // Measurement runs on the same cycle as the stage-2 outputs it describes
  logic             de_fall, line_bad, frame_ok;
  logic [DIM_W-1:0] frame_w;
  logic [DIM_W-1:0] pix_d, pix_q, line_d, line_q;
  logic [DIM_W-1:0] prev_w_d, prev_w_q, first_w_d, first_w_q;
  logic             incons_d, incons_q;

  always_comb begin
    de_fall  = de_q & ~de_d;
    pix_d    = pix_q;
    if (newline_d)                   pix_d = DIM_ONE;
    else if (de_d && pix_q != DIM_MAX) pix_d = pix_q + DIM_ONE;
    line_d   = line_q;
    if (vsync_rise)                        line_d = '0;
    else if (newline_d && line_q != DIM_MAX) line_d = line_q + DIM_ONE;
    frame_w  = first_w_q;
    line_bad = 1'b0;
    if (de_fall) begin
      if (line_q == DIM_ONE)                       frame_w  = pix_q;
      else if (line_q > DIM_ONE && pix_q != prev_w_q) line_bad = 1'b1;
    end
    prev_w_d  = de_fall ? pix_q : prev_w_q;
    // A line ending or an error on the vsync edge still belongs to the closing frame
    frame_ok  = ~(incons_q | err_d | line_bad) && (line_q != '0);
    incons_d  = vsync_rise ? 1'b0 : (incons_q | err_d | line_bad);
    first_w_d = vsync_rise ? '0 : frame_w;
  end

  always_ff @(posedge i_pixclk) begin
    if (reset) begin
      red_q      <= '0;
      grn_q      <= '0;
      blu_q      <= '0;
      de_q       <= 1'b0;
      hsync_q    <= 1'b0;
      vsync_q    <= 1'b0;
      err_q      <= 1'b0;
      newline_q  <= 1'b0;
      newframe_q <= 1'b0;
      pend_q     <= 1'b0;
      pix_q      <= '0;
      line_q     <= '0;
      prev_w_q   <= '0;
      first_w_q  <= '0;
      incons_q   <= 1'b0;
    end else begin
      red_q      <= red_d;
      grn_q      <= grn_d;
      blu_q      <= blu_d;
      de_q       <= de_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      err_q      <= err_d;
      newline_q  <= newline_d;
      newframe_q <= newframe_d;
      pend_q     <= pend_d;
      pix_q      <= pix_d;
      line_q     <= line_d;
      prev_w_q   <= prev_w_d;
      first_w_q  <= first_w_d;
      incons_q   <= incons_d;
    end
  end

  typedef enum logic [1:0] {ST_UNLOCKED, ST_SEARCH, ST_LOCKED} lock_state_t;

  lock_state_t      state_q;
  logic [MATCH_W-1:0] match_q;
  logic [DIM_W-1:0] cand_w_q, cand_h_q, width_q, height_q;
  logic             cand_ok_q, locked_q;

  always_ff @(posedge i_pixclk) begin
    if (reset) begin
      state_q   <= ST_UNLOCKED;
      match_q   <= '0;
      cand_w_q  <= '0;
      cand_h_q  <= '0;
      cand_ok_q <= 1'b0;
      width_q   <= '0;
      height_q  <= '0;
      locked_q  <= 1'b0;
    end else if (vsync_rise) begin
      case (state_q)
        ST_UNLOCKED: begin
          state_q   <= ST_SEARCH;
          cand_w_q  <= frame_w;
          cand_h_q  <= line_q;
          cand_ok_q <= frame_ok;
          match_q   <= '0;
        end
        ST_SEARCH: begin
          if (frame_ok && cand_ok_q && frame_w == cand_w_q && line_q == cand_h_q) begin
            match_q <= match_q + MATCH_ONE;
            if (match_q + MATCH_ONE >= MATCH_LAST) begin
              state_q  <= ST_LOCKED;
              width_q  <= frame_w;
              height_q <= line_q;
              locked_q <= 1'b1;
            end
          end else begin
            cand_w_q  <= frame_w;
            cand_h_q  <= line_q;
            cand_ok_q <= frame_ok;
            match_q   <= '0;
          end
        end
        ST_LOCKED: begin
          // Dimensions stay visible after losing lock; only the flag drops
          if (!frame_ok || frame_w != width_q || line_q != height_q) begin
            state_q  <= ST_UNLOCKED;
            locked_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_UNLOCKED;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_red      = red_q;
  assign o_grn      = grn_q;
  assign o_blu      = blu_q;
  assign o_de       = de_q;
  assign o_hsync    = hsync_q;
  assign o_vsync    = vsync_q;
  assign o_err      = err_q;
  assign o_newline  = newline_q;
  assign o_newframe = newframe_q;
  assign o_width    = width_q;
  assign o_height   = height_q;
  assign o_locked   = locked_q;

endmodule

// File: tb/tb_tmds_rx_decode.sv
// Bench for tmds_rx_decode: decode table, randomized traffic against a symbol-level
// model, then frame sequences for lock, loss of lock and reset behaviour.
module tb_tmds_rx_decode;

  localparam int DIM_W = 12;
  localparam int FW    = 64;
  localparam int FH    = 48;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [9:0]       r_sym, g_sym, b_sym;
  logic [7:0]       o_red, o_grn, o_blu;
  logic             o_de, o_hsync, o_vsync, o_newline, o_newframe, o_locked, o_err;
  logic [DIM_W-1:0] o_width, o_height;

  always #5 clk = ~clk;

  tmds_rx_decode #(.LOCK_FRAMES(2), .DIM_W(DIM_W)) dut (
    .i_pixclk(clk), .reset(reset),
    .i_TMDS_red(r_sym), .i_TMDS_grn(g_sym), .i_TMDS_blu(b_sym),
    .o_red(o_red), .o_grn(o_grn), .o_blu(o_blu), .o_de(o_de),
    .o_hsync(o_hsync), .o_vsync(o_vsync), .o_newline(o_newline), .o_newframe(o_newframe),
    .o_width(o_width), .o_height(o_height), .o_locked(o_locked), .o_err(o_err)
  );

  // One channel as the transmitter intends it: a pixel byte or a control code
  typedef struct packed { logic tok; logic inv; logic [7:0] val; } ch_t;
  typedef struct packed {
    logic de; logic [7:0] r; logic [7:0] g; logic [7:0] b;
    logic hs; logic vs; logic err; logic nl; logic nf;
  } obs_t;
  typedef struct { ch_t r; ch_t g; ch_t b; obs_t exp; } vec_t;

  int   n_checks = 0;
  int   n_errs   = 0;
  int   nl_cnt   = 0;
  int   nf_cnt   = 0;
  obs_t exp_q[$];
  obs_t last_act;
  logic m_hs = 0, m_vs = 0, m_prev_de = 0, m_pend = 0;
  logic last_vs = 0, last_locked = 0, lk_pre, lk_at;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] enc(input logic [7:0] d, input logic inv);
    logic [8:0] qm;
    int   n1;
    logic use_xnor;
    n1       = $countones(d);
    use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0]    = d[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = ~use_xnor;
    return {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
  endfunction

  function automatic logic [9:0] tok_sym(input logic [1:0] c);
    case (c)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  function automatic logic [9:0] sym_of(input ch_t c);
    return c.tok ? tok_sym(c.val[1:0]) : enc(c.val, c.inv);
  endfunction

  function automatic ch_t mk_d(input logic [7:0] v);
    ch_t c;
    c.tok = 1'b0; c.inv = 1'($urandom_range(0, 1)); c.val = v;
    return c;
  endfunction

  function automatic ch_t mk_t(input logic [1:0] code);
    ch_t c;
    c.tok = 1'b1; c.inv = 1'b0; c.val = {6'd0, code};
    return c;
  endfunction

  function automatic obs_t ob(input logic de, input logic [7:0] r, input logic [7:0] g,
                              input logic [7:0] b, input logic hs, input logic vs,
                              input logic err, input logic nl, input logic nf);
    obs_t o;
    o.de = de; o.r = r; o.g = g; o.b = b; o.hs = hs; o.vs = vs;
    o.err = err; o.nl = nl; o.nf = nf;
    return o;
  endfunction

  // Drive one symbol triple, advance a clock, and check the triple driven one step earlier
  task automatic step(input ch_t cr, input ch_t cg, input ch_t cb);
    obs_t e, a;
    logic all_d, all_c, new_vs;
    r_sym = sym_of(cr);
    g_sym = sym_of(cg);
    b_sym = sym_of(cb);
    all_d  = !cr.tok && !cg.tok && !cb.tok;
    all_c  = cr.tok && cg.tok && cb.tok;
    new_vs = m_vs;
    if (all_c) begin
      m_hs   = cb.val[0];
      new_vs = cb.val[1];
    end
    e = ob(all_d, all_d ? cr.val : 8'd0, all_d ? cg.val : 8'd0, all_d ? cb.val : 8'd0,
           m_hs, new_vs, !all_d && !all_c, all_d && !m_prev_de, 1'b0);
    e.nf = e.nl && m_pend;
    if (new_vs && !m_vs) m_pend = 1'b1;
    else if (e.nl)       m_pend = 1'b0;
    m_vs      = new_vs;
    m_prev_de = all_d;
    exp_q.push_back(e);
    @(negedge clk);
    a = {o_de, o_red, o_grn, o_blu, o_hsync, o_vsync, o_err, o_newline, o_newframe};
    last_act = a;
    if (o_newline)  nl_cnt++;
    if (o_newframe) nf_cnt++;
    if (o_vsync && !last_vs) begin
      lk_pre = last_locked;
      lk_at  = o_locked;
    end
    last_vs     = o_vsync;
    last_locked = o_locked;
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      check("stream", 64'(a), 64'(e));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    r_sym = tok_sym(2'b00); g_sym = tok_sym(2'b00); b_sym = tok_sym(2'b00);
    @(negedge clk);
    check("reset_outputs", 64'({o_de, o_red, o_grn, o_blu, o_hsync, o_vsync, o_newline,
                               o_newframe, o_width, o_height, o_locked, o_err}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    m_hs = 0; m_vs = 0; m_prev_de = 0; m_pend = 0;
    last_vs = 0; last_locked = 0;
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) step(mk_t(2'b00), mk_t(2'b00), mk_t(2'b00));
  endtask

  task automatic send_line(input int w);
    for (int i = 0; i < w; i++)
      step(mk_d(8'($urandom)), mk_d(8'($urandom)), mk_d(8'($urandom)));
    blank(6);
  endtask

  task automatic send_vsync();
    lk_pre = 1'bx;
    lk_at  = 1'bx;
    for (int i = 0; i < 4; i++) step(mk_t(2'b00), mk_t(2'b00), mk_t(2'b10));
    blank(4);
  endtask

  // short_line gets one pixel less; err_line is followed by one mixed symbol in blanking
  task automatic send_frame(input int short_line, input int err_line);
    for (int l = 0; l < FH; l++) begin
      send_line(l == short_line ? FW - 1 : FW);
      if (l == err_line) begin
        step(mk_d(8'h3C), mk_t(2'b00), mk_t(2'b00));
        blank(2);
      end
    end
  endtask

  vec_t tbl[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{mk_d(8'h00), mk_d(8'h00), mk_d(8'h00), ob(1, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 0)};
    tbl[1] = '{mk_d(8'h5A), mk_d(8'h5A), mk_d(8'h5A), ob(1, 8'h5A, 8'h5A, 8'h5A, 0, 0, 0, 0, 0)};
    tbl[2] = '{mk_d(8'hFF), mk_d(8'hFF), mk_d(8'hFF), ob(1, 8'hFF, 8'hFF, 8'hFF, 0, 0, 0, 0, 0)};
    tbl[3] = '{mk_d(8'hA5), mk_d(8'hA5), mk_d(8'hA5), ob(1, 8'hA5, 8'hA5, 8'hA5, 0, 0, 0, 0, 0)};
    tbl[4] = '{mk_t(2'b00), mk_t(2'b00), mk_t(2'b00), ob(0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0)};
    tbl[5] = '{mk_t(2'b00), mk_t(2'b00), mk_t(2'b01), ob(0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 0)};
    tbl[6] = '{mk_t(2'b00), mk_t(2'b00), mk_t(2'b10), ob(0, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0, 0)};
    tbl[7] = '{mk_t(2'b00), mk_t(2'b00), mk_t(2'b11), ob(0, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0, 0)};
    tbl[8] = '{mk_d(8'h33), mk_t(2'b00), mk_t(2'b00), ob(0, 8'h00, 8'h00, 8'h00, 1, 1, 1, 0, 0)};
    tbl[9] = '{mk_t(2'b00), mk_t(2'b00), mk_t(2'b01), ob(0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 0)};

    do_reset();
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) step(tbl[i].r, tbl[i].g, tbl[i].b);
      else        blank(1);
      if (i > 0) check($sformatf("vec%0d", i - 1), 64'(last_act), 64'(tbl[i-1].exp));
    end

    for (int i = 0; i < 3000; i++) begin
      ch_t c[3];
      int  kind;
      kind = int'($urandom_range(0, 9));
      for (int k = 0; k < 3; k++) begin
        if (kind <= 5)      c[k] = mk_d(8'($urandom));
        else if (kind <= 8) c[k] = mk_t(2'($urandom));
        else                c[k] = ($urandom_range(0, 1) == 1) ? mk_d(8'($urandom)) : mk_t(2'($urandom));
      end
      if (kind == 9 && c[0].tok == c[1].tok && c[1].tok == c[2].tok)
        c[0] = c[0].tok ? mk_d(8'($urandom)) : mk_t(2'($urandom));
      step(c[0], c[1], c[2]);
    end

    do_reset();
    send_vsync();
    check("v1_locked", 64'(lk_at), 64'd0);
    nl_cnt = 0; nf_cnt = 0;
    send_frame(-1, -1);
    check("frame_newlines", 64'(nl_cnt), 64'(FH));
    check("frame_newframes", 64'(nf_cnt), 64'd1);
    send_vsync();
    check("v2_locked", 64'(lk_at), 64'd0);
    send_frame(-1, -1);
    send_vsync();
    check("v3_locked_before", 64'(lk_pre), 64'd0);
    check("v3_locked", 64'(lk_at), 64'd1);
    check("v3_width", 64'(o_width), 64'(FW));
    check("v3_height", 64'(o_height), 64'(FH));
    send_frame(-1, -1);
    send_vsync();
    check("v4_locked", 64'(lk_at), 64'd1);
    send_frame(10, -1);
    send_vsync();
    check("short_line_locked", 64'(lk_at), 64'd0);
    check("short_line_width", 64'(o_width), 64'(FW));
    check("short_line_height", 64'(o_height), 64'(FH));
    send_frame(-1, -1);
    send_vsync();
    check("v6_locked", 64'(lk_at), 64'd0);
    send_frame(-1, -1);
    send_vsync();
    check("relock", 64'(lk_at), 64'd1);
    send_frame(-1, 20);
    send_vsync();
    check("err_frame_locked", 64'(lk_at), 64'd0);
    check("err_frame_width", 64'(o_width), 64'(FW));

    send_vsync();
    for (int l = 0; l < 5; l++) send_line(FW);
    for (int i = 0; i < 30; i++) step(mk_d(8'($urandom)), mk_d(8'($urandom)), mk_d(8'($urandom)));
    do_reset();
    nl_cnt = 0; nf_cnt = 0;
    for (int l = 0; l < 3; l++) send_line(FW);
    check("post_reset_newframes", 64'(nf_cnt), 64'd0);
    check("post_reset_newlines", 64'(nl_cnt), 64'd3);
    send_vsync();
    for (int l = 0; l < 2; l++) send_line(FW);
    check("post_vsync_newframes", 64'(nf_cnt), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/tmds_rx_decode.md
TMDS_RX_DECODE -- requirements
Module: tmds_rx_decode

Interface
REQ-001 SHALL have parameter LOCK_FRAMES, default 2: consecutive matching frames required to assert o_locked.
REQ-002 SHALL have parameter DIM_W, default 12: width of all pixel and line counters and dimension outputs.
REQ-003 SHALL have port i_pixclk, input, 1: pixel clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset; clock is i_pixclk.
REQ-005 SHALL have ports i_TMDS_red, i_TMDS_grn, i_TMDS_blu, input, 10 each: word-aligned TMDS symbols, one per clock.
REQ-006 SHALL have ports o_red, o_grn, o_blu, output, 8 each: decoded pixel data.
REQ-007 SHALL have port o_de, output, 1: data enable (active video).
REQ-008 SHALL have ports o_hsync and o_vsync, output, 1 each: blue-channel control bits C0 and C1.
REQ-009 SHALL have ports o_newline and o_newframe, output, 1 each: start-of-line and start-of-frame strobes.
REQ-010 SHALL have ports o_width and o_height, output, DIM_W each: measured active pixels per line and active lines per frame.
REQ-011 SHALL have ports o_locked and o_err, output, 1 each: timing-lock flag and symbol-error strobe.

Function
REQ-012 Data decode SHALL be: q[9]=1 -> invert q[7:0]; d[0]=q[0]; for i=1..7, d[i]=q[i]^q[i-1] if q[8]=1, else ~(q[i]^q[i-1]).
REQ-013 Control tokens SHALL be: 1101010100 -> C1C0=00; 0010101011 -> 01; 0101010100 -> 10; 1010101011 -> 11.
REQ-014 A channel SHALL be "control" iff its symbol equals one of the four tokens; otherwise it is "data".
REQ-015 All outputs except o_width, o_height and o_locked SHALL have a fixed 2-cycle latency from the symbol input.
REQ-016 o_de SHALL be 1 iff all three channels are data.
REQ-017 When all three channels are control, o_de SHALL be 0 and o_hsync/o_vsync SHALL update from the blue token; red/green tokens SHALL be ignored.
REQ-018 Mixed data/control across channels SHALL pulse o_err for 1 cycle, force o_de=0 and hold o_hsync/o_vsync.
REQ-019 When o_de=0, o_red/o_grn/o_blu SHALL be 0.
REQ-020 o_newline SHALL pulse for 1 cycle, coincident with the first o_de=1 cycle of each line (o_de rising edge).
REQ-021 o_newframe SHALL pulse together with o_newline on the first active line after each o_vsync rising edge; it SHALL not pulse otherwise.
REQ-022 The pixel counter SHALL count o_de cycles within a line, clear on o_newline and saturate at 2^DIM_W-1.
REQ-023 The line counter SHALL count o_newline pulses within a frame, clear on o_vsync rising edge and saturate at 2^DIM_W-1.
REQ-024 On o_de falling edge the pixel count SHALL be compared with the previous line's count; any mismatch marks the frame inconsistent.
REQ-025 On o_vsync rising edge the candidate frame (first-line width, line count) SHALL be evaluated; the counters clear in the same cycle.
REQ-026 Lock FSM states SHALL be UNLOCKED, SEARCH and LOCKED; o_locked=1 only in LOCKED.
REQ-027 UNLOCKED -> SEARCH SHALL occur on the first o_vsync rising edge, capturing the candidate dimensions and setting match count=0.
REQ-028 In SEARCH, at each vsync edge: a consistent frame equal to the previous candidate increments match; otherwise the new candidate is stored and match=0.
REQ-029 SEARCH -> LOCKED SHALL occur when match reaches LOCK_FRAMES-1; o_width and o_height SHALL load at that transition.
REQ-030 In LOCKED, an inconsistent or unequal frame at a vsync edge SHALL cause a transition to UNLOCKED without clearing o_width/o_height.
REQ-031 An o_err pulse in any state SHALL mark the current frame inconsistent.
REQ-032 A frame with zero active lines SHALL be treated as inconsistent.
REQ-033 If o_err and o_vsync rise in the same cycle, the frame closing at that edge SHALL be inconsistent.

Reset
REQ-034 While reset=1: all outputs SHALL be 0, the FSM SHALL be UNLOCKED, all counters SHALL be 0 and the pipeline SHALL be flushed.
REQ-035 Reset asserted mid-line or mid-frame SHALL discard the partial measurement; the first vsync edge after release SHALL enter SEARCH.

Verification
REQ-036 Encode 0x00, 0x5A, 0xFF, 0xA5 on all channels with an encoder model -> same values on o_red/o_grn/o_blu 2 cycles later, o_de=1.
REQ-037 Blue tokens 00/01/10/11 with red/green token 00 -> o_hsync,o_vsync = 0,0 / 1,0 / 0,1 / 1,1, o_de=0, no o_err.
REQ-038 Send 3 frames of 640x480 active video (LOCK_FRAMES=2) -> o_locked rises at the 3rd vsync edge, o_width=640, o_height=480.
REQ-039 Locked at 640x480, then one line of 639 pixels -> o_locked=0 at the next vsync edge and o_width stays 640.
REQ-040 Red symbol is data while green and blue are tokens -> o_err=1 for exactly 1 cycle, o_de=0 and syncs held.
REQ-041 Reset pulsed mid-frame -> all outputs are 0 the next cycle and o_newframe pulses only after the next vsync edge.
